// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified instruction/data memory read path.
package cpu_mem_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LD = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } tag_t;

   localparam int MEM_LAT = 2;

endpackage

// File: rtl/mem_tag_pipe.sv
// Ownership tags that travel beside each read through the fixed memory latency.
module mem_tag_pipe
   import cpu_mem_pkg::*;
#(
   parameter int LAT = MEM_LAT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       in_owner,
   input  logic [1:0] kill,
   output logic       out_valid,
   output logic       out_owner,
   output logic       busy
);

   tag_t tag_q [LAT];
   tag_t tag_d [LAT];

   // Kill applies to the shifted value, so the tag at the output this cycle still responds.
   always_comb begin
      tag_d[0] = '{valid: in_valid, owner: owner_e'(in_owner)};
      for (int i = 1; i < LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      for (int i = 0; i < LAT; i++) begin
         if ((tag_d[i].owner == OWN_IF) ? kill[0] : kill[1]) begin
            tag_d[i].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= '{valid: 1'b0, owner: OWN_IF};
         end
      end else begin
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         busy = busy | tag_q[i].valid;
      end
   end

   assign out_valid = tag_q[LAT-1].valid;
   assign out_owner = tag_q[LAT-1].owner;

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares memory read port #0 between instruction fetch and data loads,
// routing each returning word back to the requester that issued it.
module mem_read_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int AW   = 16,
   parameter int DW   = 16,
   parameter int LAT  = MEM_LAT,
   parameter int PRIO = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req_valid,
   input  logic [AW-1:0] if_req_addr,
   output logic          if_req_ready,
   input  logic          if_flush,
   output logic          if_rsp_valid,
   output logic [DW-1:0] if_rsp_data,
   input  logic          ld_req_valid,
   input  logic [AW-1:0] ld_req_addr,
   output logic          ld_req_ready,
   output logic          ld_rsp_valid,
   output logic [DW-1:0] ld_rsp_data,
   output logic [AW-1:0] mem_raddr,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   logic [AW-1:0] raddr_q, raddr_d;
   owner_e        rr_last_q, rr_last_d;
   logic          if_cand, ld_cand;
   logic          if_win, ld_win, grant;
   logic          out_valid, out_owner;

   // A flushing fetch stream is not a candidate, so a concurrent load wins outright.
   always_comb begin
      if_cand = rst_n & if_req_valid & ~if_flush;
      ld_cand = rst_n & ld_req_valid;
      if (PRIO == 1) begin
         ld_win = ld_cand;
      end else begin
         ld_win = ld_cand & (~if_cand | (rr_last_q == OWN_IF));
      end
      if_win = if_cand & ~ld_win;
      grant  = if_win | ld_win;

      mem_raddr = raddr_q;
      if (ld_win) begin
         mem_raddr = ld_req_addr;
      end else if (if_win) begin
         mem_raddr = if_req_addr;
      end
      raddr_d = mem_raddr;

      rr_last_d = rr_last_q;
      if (grant) begin
         rr_last_d = ld_win ? OWN_LD : OWN_IF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr_q   <= '0;
         rr_last_q <= OWN_LD;
      end else begin
         raddr_q   <= raddr_d;
         rr_last_q <= rr_last_d;
      end
   end

   assign if_req_ready = if_win;
   assign ld_req_ready = ld_win;

   mem_tag_pipe #(
      .LAT (LAT)
   ) u_tag_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (grant),
      .in_owner  (ld_win),
      .kill      ({1'b0, if_flush}),
      .out_valid (out_valid),
      .out_owner (out_owner),
      .busy      (busy)
   );

   assign if_rsp_valid = out_valid & (out_owner == OWN_IF);
   assign ld_rsp_valid = out_valid & (out_owner == OWN_LD);
   assign if_rsp_data  = mem_rdata;
   assign ld_rsp_data  = mem_rdata;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter against an in-flight transaction list model.
module tb_mem_read_arbiter;
   import cpu_mem_pkg::*;

   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int LAT  = MEM_LAT;
   localparam int PRIO = 0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req_valid, if_req_ready, if_flush, if_rsp_valid;
   logic [AW-1:0] if_req_addr;
   logic [DW-1:0] if_rsp_data;
   logic          ld_req_valid, ld_req_ready, ld_rsp_valid;
   logic [AW-1:0] ld_req_addr;
   logic [DW-1:0] ld_rsp_data;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   always #5 clk = ~clk;

   mem_read_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .PRIO(PRIO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_valid (if_req_valid),
      .if_req_addr  (if_req_addr),
      .if_req_ready (if_req_ready),
      .if_flush     (if_flush),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .ld_req_valid (ld_req_valid),
      .ld_req_addr  (ld_req_addr),
      .ld_req_ready (ld_req_ready),
      .ld_rsp_valid (ld_rsp_valid),
      .ld_rsp_data  (ld_rsp_data),
      .mem_raddr    (mem_raddr),
      .mem_rdata    (mem_rdata),
      .busy         (busy)
   );

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // Memory model: data for an address appears LAT cycles after it was presented.
   logic [AW-1:0] ahist [LAT];
   always @(posedge clk) begin
      ahist[0] <= mem_raddr;
      for (int i = 1; i < LAT; i++) ahist[i] <= ahist[i-1];
   end
   assign mem_rdata = mem_f(ahist[LAT-1]);

   typedef struct {
      bit            own;
      logic [AW-1:0] addr;
      int            due;
      bit            alive;
   } ent_t;

   ent_t          q[$];
   int            cyc = 0;
   bit            rr_ld = 1'b1;
   logic [AW-1:0] held = '0;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic cycle(input bit iv, input logic [AW-1:0] ia, input bit lv,
                        input logic [AW-1:0] la, input bit fl,
                        output bit ig, output bit lg);
      bit            e_ifv, e_ldv, e_busy, if_c;
      logic [DW-1:0] e_ifd, e_ldd;
      logic [AW-1:0] e_addr;
      @(negedge clk);
      if_req_valid = iv; if_req_addr = ia;
      ld_req_valid = lv; ld_req_addr = la;
      if_flush     = fl;
      #1;
      if_c = iv && !fl;
      lg   = lv && (PRIO == 1 || !if_c || !rr_ld);
      ig   = if_c && !lg;
      e_addr = lg ? la : (ig ? ia : held);
      check("if_req_ready", {31'b0, if_req_ready}, {31'b0, ig});
      check("ld_req_ready", {31'b0, ld_req_ready}, {31'b0, lg});
      check("mem_raddr", {16'b0, mem_raddr}, {16'b0, e_addr});
      e_ifv = 0; e_ldv = 0; e_busy = 0; e_ifd = '0; e_ldd = '0;
      foreach (q[k]) begin
         if (q[k].alive) begin
            if (q[k].due == cyc) begin
               if (q[k].own) begin e_ldv = 1; e_ldd = mem_f(q[k].addr); end
               else begin e_ifv = 1; e_ifd = mem_f(q[k].addr); end
            end
            if (q[k].due >= cyc) e_busy = 1;
         end
      end
      check("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, e_ifv});
      check("ld_rsp_valid", {31'b0, ld_rsp_valid}, {31'b0, e_ldv});
      check("busy", {31'b0, busy}, {31'b0, e_busy});
      if (e_ifv) check("if_rsp_data", {16'b0, if_rsp_data}, {16'b0, e_ifd});
      if (e_ldv) check("ld_rsp_data", {16'b0, ld_rsp_data}, {16'b0, e_ldd});
      if (fl) begin
         foreach (q[k]) if (!q[k].own && q[k].due > cyc) q[k].alive = 0;
      end
      if (ig || lg) begin
         q.push_back('{own: lg, addr: e_addr, due: cyc + LAT, alive: 1'b1});
         held  = e_addr;
         rr_ld = lg;
      end
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      if_req_valid = 1'b1; ld_req_valid = 1'b1; if_flush = 1'b0;
      #1;
      check("rst_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
      check("rst_ld_rsp_valid", {31'b0, ld_rsp_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_if_ready", {31'b0, if_req_ready}, 32'd0);
      check("rst_ld_ready", {31'b0, ld_req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      if_req_valid = 1'b0; ld_req_valid = 1'b0;
      rst_n = 1'b1;
      q.delete();
      rr_ld = 1'b1;
      held  = '0;
   endtask

   task automatic idle(input int n);
      bit ig, lg;
      for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0, ig, lg);
   endtask

   initial begin
      bit            ig, lg, ip, lp;
      logic [AW-1:0] ia, la;
      rst_n = 1'b0;
      if_req_valid = 0; if_req_addr = '0; if_flush = 0;
      ld_req_valid = 0; ld_req_addr = '0;
      do_reset();

      // Lone fetch
      cycle(1, 16'h0005, 0, '0, 0, ig, lg);
      idle(3);

      // Contention with hold-until-accepted requesters
      ia = 16'h0010; la = 16'h0100;
      for (int i = 0; i < 4; i++) begin
         cycle(1, ia, 1, la, 0, ig, lg);
         if (ig) ia++;
         if (lg) la++;
      end
      idle(3);

      // Flush killing an in-flight fetch while a load proceeds
      cycle(1, 16'h0020, 0, '0, 0, ig, lg);
      cycle(1, 16'h0021, 1, 16'h0200, 1, ig, lg);
      idle(3);

      // Streaming fetch
      for (int i = 0; i < 8; i++) cycle(1, AW'(i), 0, '0, 0, ig, lg);
      idle(3);

      // Reset with a load in flight, then a tie goes to IF
      cycle(0, '0, 1, 16'h0300, 0, ig, lg);
      do_reset();
      cycle(1, 16'h0000, 1, 16'h0100, 0, ig, lg);
      idle(3);

      // Randomized traffic with flushes and one asynchronous reset
      ip = 0; lp = 0; ia = '0; la = '0;
      for (int n = 0; n < 400; n++) begin
         if (!ip && ($urandom % 4) != 0) begin ip = 1; ia = AW'($urandom); end
         if (!lp && ($urandom % 3) == 0) begin lp = 1; la = AW'($urandom); end
         cycle(ip, ia, lp, la, ($urandom % 10) == 0, ig, lg);
         if (ig) ip = 0;
         if (lg) lp = 0;
         if (n == 200) do_reset();
      end
      idle(LAT + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
